// File: rtl/id_ex_operand_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage_pkg
//   Shared definitions for the ID/EX operand stage: datapath width defaults
//   and the ALU operation codes carried in alu_sel.
//   Optional feature macro used by this slice: OPERAND_FWD_EN.
// -----------------------------------------------------------------------------
package id_ex_operand_stage_pkg;

   localparam int unsigned XLEN_DEF   = 32;
   localparam int unsigned REG_AW_DEF = 5;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9,
      ALU_LUI  = 4'd10
   } alu_sel_e;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage_if
//   Bundles the ID-side instruction bus, pipeline control (flush/ex_hold),
//   the EX/MEM and MEM/WB producer buses and the EX-stage outputs.
//   master : pipeline environment (drives id_*, flush, ex_hold, exm_*, wb_*)
//   slave  : operand stage (drives id_ready and ex_*)
// -----------------------------------------------------------------------------
interface id_ex_operand_stage_if
   import id_ex_operand_stage_pkg::*;
#(
   parameter int unsigned XLEN   = XLEN_DEF,
   parameter int unsigned REG_AW = REG_AW_DEF
);
   logic              id_valid;
   logic              id_ready;
   logic [XLEN-1:0]   id_pc;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic [XLEN-1:0]   id_rs1_data;
   logic [XLEN-1:0]   id_rs2_data;
   logic [XLEN-1:0]   id_imm;
   logic [REG_AW-1:0] id_rd;
   logic [3:0]        id_alu_sel;
   logic              id_src1_pc;
   logic              id_src2_imm;
   logic              id_reg_we;
   logic              id_is_load;

   logic              flush;
   logic              ex_hold;

   logic [REG_AW-1:0] exm_rd;
   logic              exm_reg_we;
   logic [XLEN-1:0]   exm_result;
   logic [REG_AW-1:0] wb_rd;
   logic              wb_reg_we;
   logic [XLEN-1:0]   wb_data;

   logic              ex_valid;
   logic [3:0]        ex_alu_sel;
   logic [XLEN-1:0]   ex_data1;
   logic [XLEN-1:0]   ex_data2;
   logic [XLEN-1:0]   ex_store_data;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_reg_we;
   logic              ex_is_load;
   logic [XLEN-1:0]   ex_pc;

   modport master (
      output id_valid, id_pc, id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_imm,
             id_rd, id_alu_sel, id_src1_pc, id_src2_imm, id_reg_we, id_is_load,
             flush, ex_hold, exm_rd, exm_reg_we, exm_result, wb_rd, wb_reg_we, wb_data,
      input  id_ready, ex_valid, ex_alu_sel, ex_data1, ex_data2, ex_store_data,
             ex_rd, ex_reg_we, ex_is_load, ex_pc
   );

   modport slave (
      input  id_valid, id_pc, id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_imm,
             id_rd, id_alu_sel, id_src1_pc, id_src2_imm, id_reg_we, id_is_load,
             flush, ex_hold, exm_rd, exm_reg_we, exm_result, wb_rd, wb_reg_we, wb_data,
      output id_ready, ex_valid, ex_alu_sel, ex_data1, ex_data2, ex_store_data,
             ex_rd, ex_reg_we, ex_is_load, ex_pc
   );
endinterface

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// -----------------------------------------------------------------------------
// fwd_mux
//   Selects the freshest value of one source register: EX/MEM producer first,
//   then MEM/WB producer, else the value captured at ID. Producers writing x0
//   are ignored.
//   Ports: i_rs (source index), i_captured, i_exm_we/i_exm_rd/i_exm_result,
//          i_wb_we/i_wb_rd/i_wb_data, o_operand.
// -----------------------------------------------------------------------------
module fwd_mux #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned REG_AW = 5
) (
   input  logic [REG_AW-1:0] i_rs,
   input  logic [XLEN-1:0]   i_captured,
   input  logic              i_exm_we,
   input  logic [REG_AW-1:0] i_exm_rd,
   input  logic [XLEN-1:0]   i_exm_result,
   input  logic              i_wb_we,
   input  logic [REG_AW-1:0] i_wb_rd,
   input  logic [XLEN-1:0]   i_wb_data,
   output logic [XLEN-1:0]   o_operand
);
   always_comb begin
      o_operand = i_captured;
      if (i_exm_we && (i_exm_rd != '0) && (i_exm_rd == i_rs)) begin
         o_operand = i_exm_result;
      end else if (i_wb_we && (i_wb_rd != '0) && (i_wb_rd == i_rs)) begin
         o_operand = i_wb_data;
      end
   end
endmodule

// File: rtl/id_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage
//   ID/EX pipeline register plus operand forwarding feeding the ALU.
//   Ports: clk, rst (synchronous, active-high), bus (id_ex_operand_stage_if.slave).
//   Macro OPERAND_FWD_EN: defined -> EX/MEM and MEM/WB forwarding, only
//   load-use stalls; undefined -> no forwarding, ID is interlocked against
//   any in-flight EX or EX/MEM writer of its source registers.
//   The WB capture bypass is present in both builds.
// -----------------------------------------------------------------------------
module id_ex_operand_stage
   import id_ex_operand_stage_pkg::*;
#(
   parameter int unsigned XLEN   = XLEN_DEF,
   parameter int unsigned REG_AW = REG_AW_DEF
) (
   input  logic               clk,
   input  logic               rst,
   id_ex_operand_stage_if.slave bus
);
   logic              r_valid;
   logic              r_reg_we;
   logic              r_is_load;
   logic              r_src1_pc;
   logic              r_src2_imm;
   logic [XLEN-1:0]   r_pc;
   logic [XLEN-1:0]   r_imm;
   logic [XLEN-1:0]   r_rs1_val;
   logic [XLEN-1:0]   r_rs2_val;
   logic [REG_AW-1:0] r_rs1;
   logic [REG_AW-1:0] r_rs2;
   logic [REG_AW-1:0] r_rd;
   logic [3:0]        r_alu_sel;

   logic              w_load_use;
   logic              w_raw_stall;
   logic              w_ready;
   logic              w_capture;
   logic              w_exm_fwd_we;
   logic              w_wb_fwd_we;
   logic [XLEN-1:0]   w_cap1;
   logic [XLEN-1:0]   w_cap2;
   logic [XLEN-1:0]   w_op1;
   logic [XLEN-1:0]   w_op2;

   function automatic logic writes(input logic we, input logic [REG_AW-1:0] rd,
                                   input logic [REG_AW-1:0] rs);
      return we && (rd != '0) && (rd == rs);
   endfunction

   always_comb begin
      w_load_use = r_valid && r_is_load && (r_rd != '0) &&
                   ((r_rd == bus.id_rs1) || (r_rd == bus.id_rs2));
`ifdef OPERAND_FWD_EN
      w_raw_stall  = 1'b0;
      w_exm_fwd_we = bus.exm_reg_we;
      w_wb_fwd_we  = bus.wb_reg_we;
`else
      // Without forwarding, ID waits until the value can reach it through the
      // regfile read or the WB capture bypass.
      w_raw_stall  = writes(r_valid && r_reg_we, r_rd, bus.id_rs1) ||
                     writes(r_valid && r_reg_we, r_rd, bus.id_rs2) ||
                     writes(bus.exm_reg_we, bus.exm_rd, bus.id_rs1) ||
                     writes(bus.exm_reg_we, bus.exm_rd, bus.id_rs2);
      // Producer enables tied off: each fwd_mux collapses to its captured value.
      w_exm_fwd_we = 1'b0;
      w_wb_fwd_we  = 1'b0;
`endif
      w_ready   = !w_load_use && !w_raw_stall && !bus.ex_hold;
      w_capture = bus.id_valid && w_ready && !bus.flush;
      w_cap1    = writes(bus.wb_reg_we, bus.wb_rd, bus.id_rs1) ? bus.wb_data : bus.id_rs1_data;
      w_cap2    = writes(bus.wb_reg_we, bus.wb_rd, bus.id_rs2) ? bus.wb_data : bus.id_rs2_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid    <= 1'b0;
         r_reg_we   <= 1'b0;
         r_is_load  <= 1'b0;
         r_src1_pc  <= 1'b0;
         r_src2_imm <= 1'b0;
         r_pc       <= '0;
         r_imm      <= '0;
         r_rs1_val  <= '0;
         r_rs2_val  <= '0;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_rd       <= '0;
         r_alu_sel  <= ALU_ADD;
      end else if (bus.flush || (!bus.ex_hold && !w_capture)) begin
         // Bubble: only the liveness/side-effect bits are cleared.
         r_valid   <= 1'b0;
         r_reg_we  <= 1'b0;
         r_is_load <= 1'b0;
      end else if (w_capture) begin
         r_valid    <= 1'b1;
         r_reg_we   <= bus.id_reg_we;
         r_is_load  <= bus.id_is_load;
         r_src1_pc  <= bus.id_src1_pc;
         r_src2_imm <= bus.id_src2_imm;
         r_pc       <= bus.id_pc;
         r_imm      <= bus.id_imm;
         r_rs1_val  <= w_cap1;
         r_rs2_val  <= w_cap2;
         r_rs1      <= bus.id_rs1;
         r_rs2      <= bus.id_rs2;
         r_rd       <= bus.id_rd;
         r_alu_sel  <= bus.id_alu_sel;
      end
   end

   fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
      .i_rs(r_rs1), .i_captured(r_rs1_val),
      .i_exm_we(w_exm_fwd_we), .i_exm_rd(bus.exm_rd), .i_exm_result(bus.exm_result),
      .i_wb_we(w_wb_fwd_we), .i_wb_rd(bus.wb_rd), .i_wb_data(bus.wb_data),
      .o_operand(w_op1)
   );

   fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
      .i_rs(r_rs2), .i_captured(r_rs2_val),
      .i_exm_we(w_exm_fwd_we), .i_exm_rd(bus.exm_rd), .i_exm_result(bus.exm_result),
      .i_wb_we(w_wb_fwd_we), .i_wb_rd(bus.wb_rd), .i_wb_data(bus.wb_data),
      .o_operand(w_op2)
   );

   assign bus.id_ready      = w_ready;
   assign bus.ex_valid      = r_valid;
   assign bus.ex_alu_sel    = r_alu_sel;
   assign bus.ex_data1      = r_src1_pc  ? r_pc  : w_op1;
   assign bus.ex_data2      = r_src2_imm ? r_imm : w_op2;
   assign bus.ex_store_data = w_op2;
   assign bus.ex_rd         = r_rd;
   assign bus.ex_reg_we     = r_reg_we;
   assign bus.ex_is_load    = r_is_load;
   assign bus.ex_pc         = r_pc;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_operand_stage
//   Directed scenarios followed by randomized traffic, all checked against a
//   behavioural model of the EX slot and the hazard/forwarding rules.
// -----------------------------------------------------------------------------
module tb_id_ex_operand_stage;

   typedef struct packed {
      logic        rst;
      logic        id_valid;
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [3:0]  sel;
      logic        s1pc;
      logic        s2imm;
      logic        we;
      logic        ld;
      logic        flush;
      logic        hold;
      logic        exm_we;
      logic [4:0]  exm_rd;
      logic [31:0] exm_res;
      logic        wb_we;
      logic [4:0]  wb_rd;
      logic [31:0] wb_data;
   } stim_t;

   // Model of the instruction sitting in EX.
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] v1;
      logic [31:0] v2;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [3:0]  sel;
      logic        s1pc;
      logic        s2imm;
      logic        we;
      logic        ld;
   } ex_t;

   logic  clk = 1'b0;
   logic  rst;
   ex_t   m = '0;
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   logic  exp_rdy;

   always #5 clk = ~clk;

   id_ex_operand_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

   id_ex_operand_stage #(.XLEN(32), .REG_AW(5)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
   endtask

   function automatic stim_t idle();
      stim_t s = '0;
      return s;
   endfunction

   // Value a source register holds from the consumer's point of view: the
   // youngest in-flight writer wins, x0 is never overwritten.
   function automatic logic [31:0] newest(input logic [4:0] rs, input logic [31:0] captured,
                                          input stim_t s);
      logic [31:0] v = captured;
`ifdef OPERAND_FWD_EN
      if (rs != 0) begin
         if (s.wb_we  && s.wb_rd  == rs) v = s.wb_data;
         if (s.exm_we && s.exm_rd == rs) v = s.exm_res;
      end
`endif
      return v;
   endfunction

   function automatic logic [31:0] regread(input logic [4:0] rs, input logic [31:0] rf,
                                           input stim_t s);
      return (s.wb_we && s.wb_rd != 0 && s.wb_rd == rs) ? s.wb_data : rf;
   endfunction

   function automatic logic ready_model(input stim_t s);
      logic [4:0] srcs [2];
      logic stall = 1'b0;
      srcs[0] = s.rs1;
      srcs[1] = s.rs2;
      foreach (srcs[i]) begin
         if (srcs[i] != 0) begin
            if (m.valid && m.ld && m.rd == srcs[i]) stall = 1'b1;
`ifndef OPERAND_FWD_EN
            if (m.valid && m.we && m.rd == srcs[i]) stall = 1'b1;
            if (s.exm_we && s.exm_rd == srcs[i])    stall = 1'b1;
`endif
         end
      end
      return !stall && !s.hold;
   endfunction

   // Drive at negedge, then compare every output against the model.
   task automatic apply(input stim_t s);
      logic [31:0] f1, f2;
      @(negedge clk);
      rst = s.rst;
      bus.id_valid = s.id_valid;  bus.id_pc = s.pc;
      bus.id_rs1 = s.rs1;         bus.id_rs2 = s.rs2;
      bus.id_rs1_data = s.d1;     bus.id_rs2_data = s.d2;
      bus.id_imm = s.imm;         bus.id_rd = s.rd;
      bus.id_alu_sel = s.sel;     bus.id_src1_pc = s.s1pc;
      bus.id_src2_imm = s.s2imm;  bus.id_reg_we = s.we;
      bus.id_is_load = s.ld;      bus.flush = s.flush;
      bus.ex_hold = s.hold;
      bus.exm_reg_we = s.exm_we;  bus.exm_rd = s.exm_rd;  bus.exm_result = s.exm_res;
      bus.wb_reg_we = s.wb_we;    bus.wb_rd = s.wb_rd;    bus.wb_data = s.wb_data;
      #1;
      exp_rdy = ready_model(s);
      f1 = newest(m.rs1, m.v1, s);
      f2 = newest(m.rs2, m.v2, s);
      check("id_ready",   bus.id_ready,      exp_rdy);
      check("ex_valid",   bus.ex_valid,      m.valid);
      check("ex_data1",   bus.ex_data1,      m.s1pc  ? m.pc  : f1);
      check("ex_data2",   bus.ex_data2,      m.s2imm ? m.imm : f2);
      check("ex_store",   bus.ex_store_data, f2);
      check("ex_alu_sel", bus.ex_alu_sel,    m.sel);
      check("ex_rd",      bus.ex_rd,         m.rd);
      check("ex_pc",      bus.ex_pc,         m.pc);
      check("ex_reg_we",  bus.ex_reg_we,     m.we);
      check("ex_is_load", bus.ex_is_load,    m.ld);
   endtask

   task automatic tick(input stim_t s);
      @(posedge clk);
      if (s.rst) begin
         m = '0;
      end else if (s.flush || (!s.hold && !(s.id_valid && exp_rdy))) begin
         m.valid = 1'b0; m.we = 1'b0; m.ld = 1'b0;
      end else if (!s.hold) begin
         m.valid = 1'b1;     m.pc = s.pc;     m.rs1 = s.rs1;   m.rs2 = s.rs2;
         m.v1 = regread(s.rs1, s.d1, s);      m.v2 = regread(s.rs2, s.d2, s);
         m.imm = s.imm;      m.rd = s.rd;     m.sel = s.sel;
         m.s1pc = s.s1pc;    m.s2imm = s.s2imm;
         m.we = s.we;        m.ld = s.ld;
      end
   endtask

   task automatic step(input stim_t s);
      apply(s);
      tick(s);
   endtask

   function automatic stim_t rand_stim();
      stim_t s;
      s.rst      = ($urandom_range(0, 63) == 0);
      s.id_valid = ($urandom_range(0, 3) != 0);
      s.pc       = $urandom;
      s.rs1      = 5'($urandom_range(0, 7));
      s.rs2      = 5'($urandom_range(0, 7));
      s.d1       = $urandom;
      s.d2       = $urandom;
      s.imm      = $urandom;
      s.rd       = 5'($urandom_range(0, 7));
      s.sel      = 4'($urandom_range(0, 10));
      s.s1pc     = ($urandom_range(0, 3) == 0);
      s.s2imm    = ($urandom_range(0, 2) == 0);
      s.we       = ($urandom_range(0, 9) < 7);
      s.ld       = ($urandom_range(0, 3) == 0);
      s.flush    = ($urandom_range(0, 15) == 0);
      s.hold     = ($urandom_range(0, 7) == 0);
      s.exm_we   = $urandom_range(0, 1) == 1;
      s.exm_rd   = 5'($urandom_range(0, 7));
      s.exm_res  = $urandom;
      s.wb_we    = $urandom_range(0, 1) == 1;
      s.wb_rd    = 5'($urandom_range(0, 7));
      s.wb_data  = $urandom;
      return s;
   endfunction

   initial begin
      stim_t s;
      rst = 1'b1;
      apply(idle());
      s = idle(); s.rst = 1'b1;
      tick(s);

      // Reset held two cycles with a valid instruction presented.
      s = idle(); s.rst = 1'b1; s.id_valid = 1'b1; s.rs1 = 5'd1; s.d1 = 32'h1234;
      s.rd = 5'd2; s.we = 1'b1;
      step(s);
      step(s);
      s = idle();
      apply(s);
      check("rst_ex_valid", bus.ex_valid, 1'b0);
      check("rst_data1",    bus.ex_data1, 32'd0);
      check("rst_data2",    bus.ex_data2, 32'd0);
      check("rst_id_ready", bus.id_ready, 1'b1);
      tick(s);

      // ADD x3,x1,x2 then SUB x4,x3,x1 with x3 arriving from EX/MEM.
      s = idle(); s.id_valid = 1'b1; s.rs1 = 5'd1; s.rs2 = 5'd2; s.d1 = 32'd5; s.d2 = 32'd7;
      s.rd = 5'd3; s.we = 1'b1; s.sel = 4'd0;
      step(s);
      s = idle(); s.id_valid = 1'b1; s.rs1 = 5'd3; s.rs2 = 5'd1; s.d1 = 32'd0; s.d2 = 32'd5;
      s.rd = 5'd4; s.we = 1'b1; s.sel = 4'd1;
      step(s);
      s = idle(); s.exm_we = 1'b1; s.exm_rd = 5'd3; s.exm_res = 32'd12;
      apply(s);
`ifdef OPERAND_FWD_EN
      check("sub_data1_fwd", bus.ex_data1, 32'd12);
      check("sub_data2",     bus.ex_data2, 32'd5);
`endif
      tick(s);

      // Load x5 then ADD x6,x5,x0: one-cycle stall, then WB forward.
      s = idle(); s.id_valid = 1'b1; s.rd = 5'd5; s.we = 1'b1; s.ld = 1'b1; s.rs1 = 5'd9;
      step(s);
      s = idle(); s.id_valid = 1'b1; s.rs1 = 5'd5; s.rs2 = 5'd0; s.d1 = 32'h0BAD; s.rd = 5'd6;
      s.we = 1'b1;
      apply(s);
      check("lu_stall", bus.id_ready, 1'b0);
      tick(s);
      apply(s);
      check("lu_bubble", bus.ex_valid, 1'b0);
`ifdef OPERAND_FWD_EN
      check("lu_release", bus.id_ready, 1'b1);
`endif
      tick(s);
      s = idle(); s.wb_we = 1'b1; s.wb_rd = 5'd5; s.wb_data = 32'hDEAD_BEEF;
      apply(s);
`ifdef OPERAND_FWD_EN
      check("lu_wb_fwd", bus.ex_data1, 32'hDEAD_BEEF);
`endif
      tick(s);

      // x0 guard.
      s = idle(); s.id_valid = 1'b1; s.rs1 = 5'd0; s.d1 = 32'd0; s.rd = 5'd8; s.we = 1'b1;
      step(s);
      s = idle(); s.exm_we = 1'b1; s.exm_rd = 5'd0; s.exm_res = 32'hFFFF_FFFF;
      s.flush = 1'b1; s.hold = 1'b1; s.id_valid = 1'b1; s.rd = 5'd11; s.we = 1'b1;
      apply(s);
      check("x0_guard", bus.ex_data1, 32'd0);
      check("x0_valid", bus.ex_valid, 1'b1);
      tick(s);

      // flush + ex_hold with a live instruction -> bubble.
      s = idle();
      apply(s);
      check("flush_valid", bus.ex_valid, 1'b0);
      check("flush_we",    bus.ex_reg_we, 1'b0);
      tick(s);

      // Both producers target x7.
      s = idle(); s.id_valid = 1'b1; s.rs1 = 5'd7; s.d1 = 32'h55; s.rd = 5'd9; s.we = 1'b1;
      step(s);
      s = idle(); s.id_valid = 1'b1; s.rs1 = 5'd7; s.rd = 5'd10; s.we = 1'b1;
      s.exm_we = 1'b1; s.exm_rd = 5'd7; s.exm_res = 32'd1;
      s.wb_we = 1'b1;  s.wb_rd = 5'd7;  s.wb_data = 32'd2;
      apply(s);
`ifdef OPERAND_FWD_EN
      check("dual_prio", bus.ex_data1, 32'd1);
`else
      check("dual_stall", bus.id_ready, 1'b0);
`endif
      tick(s);
      s.exm_we = 1'b0; s.wb_we = 1'b0;
      apply(s);
      check("dual_ready", bus.id_ready, 1'b1);
      tick(s);

      for (int i = 0; i < 600; i++) step(rand_stim());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete, got %0d checks expected completion", n_checks);
      $fatal(1);
   end

endmodule
